debug_tx_scheduler: RTL and testbench

- Sequences the UART transmitter to dump MIPS debug state to the host after a step or HALT.
- The debug_unit issues a dump request. This block walks the PC, the register file, data memory and the cycle counter, and serialises each 32-bit word into bytes over the tx_start/tx_done handshake.
- It owns the UART TX port while busy; the debug_unit muxes TX to it whenever o_busy=1.

---
 rtl/debug_tx_scheduler.sv | 173 +++++++++++++++++
 tb/tb_debug_tx_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_tx_scheduler.sv
// Walks PC, register file, data memory and cycle counter, streaming each word MSB-first over the UART handshake.
// Define DEBUG_TX_CHECKSUM_EN to append one XOR-of-all-bytes checksum byte before completion.
//
// state   | meaning
// IDLE    | waiting for a dump request
// LEER    | read address presented to the selected source
// CARGAR  | selected word latched into the shift register
// ENVIAR  | issue tx_start with the current MS byte
// ESPERAR | wait for tx_done, then next byte / next word / finish
// FIN     | done pulse, return to IDLE
module debug_tx_scheduler #(
  parameter int OUTPUT_WORD_LENGTH    = 8,
  parameter int LONGITUD_INSTRUCCION  = 32,
  parameter int CANT_REGISTROS        = 32,
  parameter int ADDR_REG_LENGTH       = 5,
  parameter int CANT_MEM_DATOS        = 16,
  parameter int ADDR_MEM_DATOS_LENGTH = 4
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic                             i_start,
  input  logic                             i_tx_done,
  input  logic [LONGITUD_INSTRUCCION-1:0]  i_pc,
  input  logic [LONGITUD_INSTRUCCION-1:0]  i_contador_ciclos,
  input  logic [LONGITUD_INSTRUCCION-1:0]  i_dato_registro,
  input  logic [LONGITUD_INSTRUCCION-1:0]  i_dato_memoria,
  output logic [ADDR_REG_LENGTH-1:0]       o_addr_registro,
  output logic [ADDR_MEM_DATOS_LENGTH-1:0] o_addr_memoria,
  output logic                             o_tx_start,
  output logic [OUTPUT_WORD_LENGTH-1:0]    o_data_tx,
  output logic                             o_busy,
  output logic                             o_done
);

  localparam int BPW    = LONGITUD_INSTRUCCION / OUTPUT_WORD_LENGTH;
  localparam int NWORDS = CANT_REGISTROS + CANT_MEM_DATOS + 2;
  localparam int WIDX_W = $clog2(NWORDS);
  localparam int BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [WIDX_W-1:0] LAST_WORD  = WIDX_W'(NWORDS - 1);
  localparam logic [WIDX_W-1:0] LAST_REG_W = WIDX_W'(CANT_REGISTROS);
  localparam logic [WIDX_W-1:0] FIRST_MEM  = WIDX_W'(CANT_REGISTROS + 1);
  localparam logic [WIDX_W-1:0] LAST_MEM_W = WIDX_W'(CANT_REGISTROS + CANT_MEM_DATOS);
  localparam logic [BIDX_W-1:0] LAST_BYTE  = BIDX_W'(BPW - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEER,
    CARGAR,
    ENVIAR,
    ESPERAR,
    FIN
  } state_t;

  state_t                          state;
  logic [WIDX_W-1:0]               word_idx;
  logic [BIDX_W-1:0]               byte_idx;
  logic [LONGITUD_INSTRUCCION-1:0] shift_reg;
  logic [LONGITUD_INSTRUCCION-1:0] sel_word;
  logic [WIDX_W-1:0]               next_word;
`ifdef DEBUG_TX_CHECKSUM_EN
  logic [OUTPUT_WORD_LENGTH-1:0]   chk;
  logic                            chk_phase;
`endif

  // word 0 = PC, then registers, then memory, last = cycle counter
  function automatic logic [ADDR_REG_LENGTH-1:0] reg_addr(input logic [WIDX_W-1:0] w);
    if (w != '0 && w <= LAST_REG_W) return ADDR_REG_LENGTH'(w - 1'b1);
    return '0;
  endfunction

  function automatic logic [ADDR_MEM_DATOS_LENGTH-1:0] mem_addr(input logic [WIDX_W-1:0] w);
    if (w >= FIRST_MEM && w <= LAST_MEM_W) return ADDR_MEM_DATOS_LENGTH'(w - FIRST_MEM);
    return '0;
  endfunction

  always_comb begin
    sel_word  = i_contador_ciclos;
    next_word = word_idx + 1'b1;
    if (word_idx == '0)              sel_word = i_pc;
    else if (word_idx <= LAST_REG_W) sel_word = i_dato_registro;
    else if (word_idx <= LAST_MEM_W) sel_word = i_dato_memoria;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state           <= IDLE;
      word_idx        <= '0;
      byte_idx        <= '0;
      shift_reg       <= '0;
      o_addr_registro <= '0;
      o_addr_memoria  <= '0;
      o_tx_start      <= 1'b0;
      o_data_tx       <= '0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
`ifdef DEBUG_TX_CHECKSUM_EN
      chk             <= '0;
      chk_phase       <= 1'b0;
`endif
    end else begin
      o_tx_start <= 1'b0;
      o_done     <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state           <= LEER;
            o_busy          <= 1'b1;
            word_idx        <= '0;
            byte_idx        <= '0;
            o_addr_registro <= '0;
            o_addr_memoria  <= '0;
`ifdef DEBUG_TX_CHECKSUM_EN
            chk             <= '0;
            chk_phase       <= 1'b0;
`endif
          end
        end
        LEER: state <= CARGAR;
        CARGAR: begin
          shift_reg       <= sel_word;
          byte_idx        <= '0;
          o_addr_registro <= '0;
          o_addr_memoria  <= '0;
          state           <= ENVIAR;
        end
        ENVIAR: begin
          o_tx_start <= 1'b1;
          o_data_tx  <= shift_reg[LONGITUD_INSTRUCCION-1 -: OUTPUT_WORD_LENGTH];
`ifdef DEBUG_TX_CHECKSUM_EN
          chk        <= chk ^ shift_reg[LONGITUD_INSTRUCCION-1 -: OUTPUT_WORD_LENGTH];
`endif
          state      <= ESPERAR;
        end
        ESPERAR: begin
          if (i_tx_done) begin
            if (byte_idx != LAST_BYTE) begin
              shift_reg <= shift_reg << OUTPUT_WORD_LENGTH;
              byte_idx  <= byte_idx + 1'b1;
              state     <= ENVIAR;
            end else if (word_idx != LAST_WORD) begin
              // address goes out with the LEER entry so it is stable through CARGAR
              word_idx        <= next_word;
              o_addr_registro <= reg_addr(next_word);
              o_addr_memoria  <= mem_addr(next_word);
              state           <= LEER;
            end else begin
`ifdef DEBUG_TX_CHECKSUM_EN
              if (!chk_phase) begin
                chk_phase <= 1'b1;
                shift_reg <= LONGITUD_INSTRUCCION'(chk) << (LONGITUD_INSTRUCCION - OUTPUT_WORD_LENGTH);
                state     <= ENVIAR;
              end else begin
                o_done <= 1'b1;
                state  <= FIN;
              end
`else
              o_done <= 1'b1;
              state  <= FIN;
`endif
            end
          end
        end
        FIN: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_tx_scheduler.sv
// Self-checking bench for debug_tx_scheduler: a UART responder, sync-read memories and a byte-stream reference model.
module tb_debug_tx_scheduler;

  localparam int OWL   = 8;
  localparam int LI    = 32;
  localparam int NR    = 2;
  localparam int NM    = 1;
  localparam int BPW   = LI / OWL;
  localparam int NDATA = BPW * (NR + NM + 2);
`ifdef DEBUG_TX_CHECKSUM_EN
  localparam int NBYTES = NDATA + 1;
`else
  localparam int NBYTES = NDATA;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        tx_done;
  logic [31:0] pc_v, cnt_v, dato_reg, dato_mem;
  logic [4:0]  addr_reg;
  logic [3:0]  addr_mem;
  logic        tx_start;
  logic [7:0]  data_tx;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  debug_tx_scheduler #(
    .OUTPUT_WORD_LENGTH(OWL),
    .LONGITUD_INSTRUCCION(LI),
    .CANT_REGISTROS(NR),
    .ADDR_REG_LENGTH(5),
    .CANT_MEM_DATOS(NM),
    .ADDR_MEM_DATOS_LENGTH(4)
  ) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .i_start(start),
    .i_tx_done(tx_done),
    .i_pc(pc_v),
    .i_contador_ciclos(cnt_v),
    .i_dato_registro(dato_reg),
    .i_dato_memoria(dato_mem),
    .o_addr_registro(addr_reg),
    .o_addr_memoria(addr_mem),
    .o_tx_start(tx_start),
    .o_data_tx(data_tx),
    .o_busy(busy),
    .o_done(done)
  );

  // register file and data memory with one cycle of read latency
  logic [31:0] rf [32];
  logic [31:0] dm [16];
  always @(posedge clk) begin
    dato_reg <= rf[addr_reg];
    dato_mem <= dm[addr_mem];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int cyc = 0;
  int resp_delay = 3, hold_len = 1, stall_byte = -1, stall_cycles = 0;
  int pend = 0, hold = 0, done_cyc = 0, first_start_cyc = 0;
  int done_cnt = 0, areg1_cnt = 0, abad = 0, stall_bad = 0;
  bit stalling = 0, prev_done = 0;
  logic [7:0] stall_val;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // UART responder and output monitor
  initial begin
    tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        pend = 0; hold = 0; tx_done = 1'b0; stalling = 0; prev_done = 0;
      end else begin
        if (prev_done) check("busy_after_done", busy, 0);
        prev_done = done;
        if (done) begin
          done_cnt++;
          check("busy_with_done", busy, 1);
        end
        if (addr_reg == 5'd1) areg1_cnt++;
        else if (addr_reg != 5'd0) abad++;
        if (addr_mem != 4'd0) abad++;
        if (stalling && (tx_start !== 1'b0 || data_tx !== stall_val || busy !== 1'b1)) stall_bad++;
        if (hold > 0) begin
          hold--;
          if (hold == 0) tx_done = 1'b0;
        end
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            tx_done  = 1'b1;
            hold     = hold_len;
            done_cyc = cyc;
            stalling = 0;
          end
        end
        if (tx_start) begin
          int n;
          n = got_q.size();
          if (n == 0) first_start_cyc = cyc;
          else check("tx_gap", cyc - done_cyc, ((n % BPW == 0) && n < NDATA) ? 4 : 2);
          got_q.push_back(data_tx);
          if (n == stall_byte) begin
            pend      = stall_cycles;
            stalling  = 1;
            stall_val = (n < exp_q.size()) ? exp_q[n] : 8'h00;
          end else begin
            pend = resp_delay;
          end
        end
      end
    end
  end

  task automatic load_data(input bit fixed);
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    for (int i = 0; i < 16; i++) dm[i] = $urandom;
    pc_v  = $urandom;
    cnt_v = $urandom;
    if (fixed) begin
      pc_v  = 32'h0000_0010;
      rf[0] = 32'h0000_0000;
      rf[1] = 32'h1122_3344;
      dm[0] = 32'hA5A5_A5A5;
      cnt_v = 32'h0000_002A;
    end
  endtask

  // expected stream: word list in dump order, each split MSB first, optional XOR trailer
  task automatic build_exp();
    logic [31:0] words[$];
    logic [7:0]  x, b;
    exp_q.delete();
    words.push_back(pc_v);
    for (int i = 0; i < NR; i++) words.push_back(rf[i]);
    for (int i = 0; i < NM; i++) words.push_back(dm[i]);
    words.push_back(cnt_v);
    x = 8'h00;
    foreach (words[w]) begin
      for (int k = BPW - 1; k >= 0; k--) begin
        b = 8'((words[w] >> (8 * k)) & 32'hFF);
        exp_q.push_back(b);
        x ^= b;
      end
    end
`ifdef DEBUG_TX_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic run_dump(input bit fixed, input int delay, input int hl,
                          input int stall_b, input int stall_c, input int restart_at);
    int start_cyc, waited, nmin;
    bit restarted;
    load_data(fixed);
    build_exp();
    got_q.delete();
    done_cnt = 0; areg1_cnt = 0; abad = 0; stall_bad = 0;
    resp_delay = delay; hold_len = hl; stall_byte = stall_b; stall_cycles = stall_c;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
    check("busy_on_start", busy, 1);
    restarted = 0;
    waited = 0;
    while (done_cnt == 0 && waited < 3000) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (restart_at >= 0 && !restarted && got_q.size() == restart_at) begin
        start = 1'b1;
        restarted = 1;
      end
      waited++;
    end
    start = 1'b0;
    check("done_seen", 32'(done_cnt > 0), 1);
    repeat (6) @(posedge clk);
    #1;
    check("done_count", done_cnt, 1);
    check("byte_count", got_q.size(), NBYTES);
    nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) check($sformatf("byte%0d", i), got_q[i], exp_q[i]);
    check("first_start_latency", first_start_cyc - start_cyc, 3);
    check("addr_reg1_cycles", areg1_cnt, 2);
    check("addr_other", abad, 0);
    if (stall_b >= 0) check("stall_hold", stall_bad, 0);
    stall_byte = -1;
  endtask

  task automatic reset_abort();
    int waited;
    load_data(1);
    build_exp();
    got_q.delete();
    resp_delay = 3; hold_len = 1; stall_byte = -1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waited = 0;
    while (got_q.size() < 9 && waited < 1000) begin
      @(posedge clk); #1;
      waited++;
    end
    check("abort_reached_byte9", 32'(got_q.size() >= 9), 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("abort_tx_start", tx_start, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_data", data_tx, 0);
    check("abort_addr", {addr_reg, addr_mem}, 0);
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    load_data(1);
    #12;
    check("rst_tx_start", tx_start, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", data_tx, 0);
    check("rst_addr_reg", addr_reg, 0);
    check("rst_addr_mem", addr_mem, 0);
    #15 rst_n = 1'b1;

    run_dump(1, 3, 1, -1, 0, -1);
    run_dump(1, 3, 1, -1, 0, 5);
    run_dump(1, 3, 1, 2, 100, -1);
    reset_abort();
    run_dump(1, 3, 1, -1, 0, -1);
    for (int t = 0; t < 6; t++)
      run_dump(0, int'($urandom_range(1, 6)), int'($urandom_range(1, 2)), -1, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
